w_port_arbiter: RTL
===================

Name: w_port_arbiter

Overview:
Round-robin arbiter that shares the write port of the asynchronous FIFO's write-clock domain between NUM_REQ requesters.
- Grants one requester at a time for a burst, terminated by that requester's last flag or by MAX_BURST beats.
- Drives the FIFO's w_en and write data, and honours w_full.
- Sits directly in front of the FIFO write side, entirely in the w_clk domain.

Parameters:
- NUM_REQ, 4: number of requesters; minimum 2.
- DATA_SIZE, 8: width of the FIFO write-data word.
- MAX_BURST, 8: maximum beats per grant; minimum 1.

Ports:
- w_clk, input, 1: write-domain clock; the only clock.
- wrst_n, input, 1: reset, synchronous, active-low.
- req_valid, input, NUM_REQ: per-requester word-valid.
- req_last, input, NUM_REQ: per-requester last-word-of-burst flag; qualified by req_valid.
- req_data, input, NUM_REQ*DATA_SIZE: packed requester data; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_ready, output, NUM_REQ: per-requester accept. A transfer occurs when req_valid[i] and req_ready[i] are both high.
- w_full, input, 1: registered full flag from the FIFO write side.
- w_en, output, 1: FIFO write enable.
- w_data, output, DATA_SIZE: FIFO write data.
- grant_id, output, clog2(NUM_REQ): index of the currently or most recently granted requester.
- busy, output, 1: high while a grant is held.

Interface decision:
- One clock; reset is synchronous and active-low (w_clk, wrst_n).
- All state updates on posedge w_clk.
- wrst_n is sampled on the clock edge only; it has no asynchronous effect.

Behaviour:
- State machine, two states:
  - IDLE: no grant held.
  - GRANT: one requester holds the port.
- Reset (wrst_n=0 at an edge):
  - state=IDLE, busy=0, grant_id=0, beat count=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has highest priority after reset.
  - While state is IDLE, w_en=0 and req_ready=0.
  - Reset mid-burst abandons the burst immediately. No partial-burst bookkeeping survives.
- IDLE behaviour:
  - If any req_valid is high, pick the first valid requester searching upward from pointer+1 with wrap-around.
  - Register that index into grant_id and go to GRANT.
  - Arbitration latency: the first beat can transfer one cycle after req_valid is seen in IDLE.
  - If no req_valid is high, stay in IDLE.
  - w_full does not block arbitration.
- GRANT behaviour:
  - busy=1.
  - req_ready[grant_id] = !w_full (combinational). All other req_ready bits = 0.
  - w_en = req_valid[grant_id] & !w_full (combinational).
  - w_data = req_data slice of grant_id, always muxed; it is meaningful only when w_en=1.
  - Each transfer increments the beat count.
- Burst termination:
  - The burst ends on a transfer with req_last[grant_id]=1, or on the transfer where the beat count reaches MAX_BURST. If both happen on the same beat, it ends once.
  - On termination: next state IDLE, pointer = grant_id, beat count cleared.
  - This gives one bubble cycle between grants, which is acceptable.
- Backpressure:
  - While w_full=1 there are no transfers, the beat count holds, and the grant holds.
  - w_full is registered in the FIFO and asserts the cycle after the filling write. The arbiter never writes while w_full=1, so no overflow is possible.
- Idle holder:
  - The grant is held even if the holder drops req_valid mid-burst, which keeps bursts atomic.
  - No beats count during such gaps.
- Fairness: a requester that just finished is lowest priority at the next arbitration. With all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Width rules:
  - Beat counter width = clog2(MAX_BURST+1).
  - grant_id width = clog2(NUM_REQ).
- X-safety: req_data and req_last of non-granted requesters are ignored.

Decomposition:
- Package w_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - a width helper function for the clog2-derived widths.
- One sub-module, rr_priority_picker (combinational), with ports:
  - req vector in;
  - pointer in;
  - granted index out;
  - any-valid out.
- The FSM, counters, muxes and ready/enable logic stay in w_port_arbiter.

Test Plan:
1. Reset priority: assert wrst_n=0 for 2 cycles while req_valid=4'b1111 → busy=0, w_en=0, req_ready=0 throughout. After release: grant_id=0 one cycle later; grants then rotate 0,1,2,3,0, each burst ending on req_last.
2. Burst cap: requester 2 holds req_valid with req_last=0, MAX_BURST=8 → exactly 8 w_en pulses carrying requester 2's data, one IDLE cycle, then re-grant to requester 2 only if no other requester is valid.
3. Full backpressure: force w_full=1 for 3 cycles mid-burst after beat 3 → w_en=0 and req_ready=0 for those 3 cycles, the beat count stays at 3, and the burst resumes at beat 4 with grant_id unchanged.
4. Simultaneous end: req_last=1 on beat 8 with MAX_BURST=8 → a single termination, the pointer advances once, and the next grant goes to the next valid requester.
5. Synchronous reset mid-burst: drop wrst_n for 1 cycle at beat 5 of requester 1 → at the next edge busy=0 and w_en=0. A pulse of wrst_n=0 between edges that is not sampled has no effect. After reset, requester 0 wins if it is valid.
6. Holder gap: requester 3 granted, drops req_valid for 4 cycles while requester 0 is valid → no writes, grant stays with 3, busy=1, and requester 0's req_ready=0 throughout.

Source files
------------

// File: rtl/w_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package w_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // ceil(log2(n)), never below 1 so single-value fields still get a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set req bit above ptr, wrapping.
module rr_priority_picker
  import w_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned cand;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!any && req[cand]) begin
        idx = IW'(cand);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w_port_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ requesters.
module w_port_arbiter
  import w_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned GW = clog2_min1(NUM_REQ),
  localparam int unsigned CW = clog2_min1(MAX_BURST + 1)
) (
  input  logic                         w_clk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         w_full,
  output logic                         w_en,
  output logic [DATA_SIZE-1:0]         w_data,
  output logic [GW-1:0]                grant_id,
  output logic                         busy
);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] gid_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          burst_end;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      grant_id <= '0;
      ptr_q    <= GW'(NUM_REQ - 1);
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= gid_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    busy      = (state_q == GRANT);
    req_ready = '0;
    w_en      = 1'b0;
    w_data    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) w_data = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
    if (busy && !w_full) begin
      req_ready[grant_id] = 1'b1;
      w_en                = req_valid[grant_id];
    end
    // last flag and beat cap may coincide; either closes the burst exactly once
    burst_end = w_en && (req_last[grant_id] || ((beat_q + CW'(1)) == CW'(MAX_BURST)));
  end

  always_comb begin
    state_d = state_q;
    gid_d   = grant_id;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gid_d   = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (burst_end) begin
          state_d = IDLE;
          ptr_d   = grant_id;
          beat_d  = '0;
        end else if (w_en) begin
          beat_d = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
